// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the PC, talks to the L1 I-cache, applies delayed branch redirects and flushes.
// Optional feature macro: IF_ADDR_ALIGN_CHECK_EN (adds if_adel and misaligned-PC trapping).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_ready,
  input  logic [31:0] ic_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_stall_req
`ifdef IF_ADDR_ALIGN_CHECK_EN
  ,
  output logic        if_adel
`endif
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state_q, state_next;
  logic [31:0] pc_q, pc_next;
  logic [31:0] tgt_q, tgt_next;
  logic        redir_pending_q, redir_pending_next;
  logic [31:0] redir_pc_q, redir_pc_next;
  logic        misalign;

`ifdef IF_ADDR_ALIGN_CHECK_EN
  logic adel_c;

  // Misaligned addresses are kept so the exception path can report them.
  function automatic logic [31:0] pc_load(input logic [31:0] a);
    return a;
  endfunction

  assign misalign = (pc_q[1:0] != 2'b00);
  assign if_adel  = adel_c;
`else
  // Without the alignment trap every PC load is word-aligned by construction.
  function automatic logic [31:0] pc_load(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      pc_q            <= pc_load(RESET_PC);
      tgt_q           <= '0;
      redir_pending_q <= 1'b0;
      redir_pc_q      <= '0;
    end else begin
      state_q         <= state_next;
      pc_q            <= pc_next;
      tgt_q           <= tgt_next;
      redir_pending_q <= redir_pending_next;
      redir_pc_q      <= redir_pc_next;
    end
  end

  always_comb begin
    ic_req             = 1'b0;
`ifdef IF_ADDR_ALIGN_CHECK_EN
    ic_addr            = pc_q;
    adel_c             = 1'b0;
`else
    ic_addr            = {pc_q[31:2], 2'b00};
`endif
    if_pc              = '0;
    if_inst            = NOP_INST;
    if_stall_req       = 1'b0;
    state_next         = state_q;
    pc_next            = pc_q;
    tgt_next           = tgt_q;
    redir_pending_next = redir_pending_q;
    redir_pc_next      = redir_pc_q;

    case (state_q)
      RUN: begin
        if (misalign) begin
          // Faulting PC is parked with no cache request until a flush redirects it.
`ifdef IF_ADDR_ALIGN_CHECK_EN
          adel_c = 1'b1;
`endif
          if_pc = pc_q;
          if (flush) begin
            pc_next            = pc_load(flush_pc);
            redir_pending_next = 1'b0;
          end
        end else begin
          ic_req       = 1'b1;
          if_stall_req = ~ic_ready;
          if (ic_ready && !flush) begin
            if_pc   = pc_q;
            if_inst = ic_rdata;
          end

          if (flush) begin
            redir_pending_next = 1'b0;
            if (ic_ready) begin
              pc_next = pc_load(flush_pc);
            end else begin
              // A request is outstanding: it must complete at the same address first.
              tgt_next   = flush_pc;
              state_next = DRAIN;
            end
          end else if (ic_ready && !stall) begin
            if (br_taken) begin
              pc_next = pc_load(br_target);
            end else if (redir_pending_q) begin
              pc_next = pc_load(redir_pc_q);
            end else begin
              pc_next = pc_q + 32'd4;
            end
            redir_pending_next = 1'b0;
          end else if (br_taken) begin
            // Delay slot still in flight or held: remember the target for the next advance.
            redir_pending_next = 1'b1;
            redir_pc_next      = br_target;
          end
        end
      end

      DRAIN: begin
        ic_req       = 1'b1;
        if_stall_req = 1'b1;
        if (ic_ready) begin
          pc_next    = pc_load(flush ? flush_pc : tgt_q);
          state_next = RUN;
        end else if (flush) begin
          tgt_next = flush_pc;
        end
      end

      default: begin
        state_next = RUN;
      end
    endcase

    // Reset also kills any outstanding request presented to the cache.
    if (rst) begin
      ic_req       = 1'b0;
      if_pc        = '0;
      if_inst      = NOP_INST;
      if_stall_req = 1'b0;
`ifdef IF_ADDR_ALIGN_CHECK_EN
      adel_c       = 1'b0;
`endif
    end
  end

endmodule
